// File: rtl/conv2d_frame_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : conv2d_frame_sequencer_pkg                                  |
// | Description : Shared types and helpers for the conv2d frame sequencer:    |
// |               FSM state encoding and frame pixel-count helper.            |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
package conv2d_frame_sequencer_pkg;

  // Frame sequencer states; encoding is fixed so it can be observed on debug taps.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Number of pixels in one frame.
  function automatic int npix(input int img_w, input int img_h);
    return img_w * img_h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv2d_frame_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : conv2d_frame_sequencer_if                                   |
// | Description : Frame RAM read port plus pixel stream to / count pulses    |
// |               from the 3x3 conv core.                                    |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
interface conv2d_frame_sequencer_if #(
  parameter int ADDR_W     = 14,
  parameter int PIXEL_BITS = 8
);
  logic                  mem_rd_en;
  logic [ADDR_W-1:0]     mem_addr;
  logic [PIXEL_BITS-1:0] mem_rd_data;
  logic [PIXEL_BITS-1:0] pixel_in;
  logic                  pixel_valid;
  logic                  core_out_vld;

  // Sequencer side: issues RAM reads, drives the pixel stream, counts core outputs.
  modport master (
    output mem_rd_en,
    output mem_addr,
    output pixel_in,
    output pixel_valid,
    input  mem_rd_data,
    input  core_out_vld
  );

  // RAM / core side.
  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    input  pixel_in,
    input  pixel_valid,
    output mem_rd_data,
    output core_out_vld
  );
endinterface
`default_nettype wire

// File: rtl/conv2d_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : conv2d_frame_sequencer                                      |
// | Description : Frame-level controller for the streaming 3x3 conv core.    |
// |               Reads one frame from a 1-cycle-latency RAM in raster order,|
// |               streams it to the core, counts core outputs and reports    |
// |               done or a timeout error.                                   |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module conv2d_frame_sequencer
  import conv2d_frame_sequencer_pkg::*;
#(
  parameter int IMG_W      = 128,
  parameter int IMG_H      = 128,
  parameter int PIXEL_BITS = 8,
  parameter int ADDR_W     = 14,
  parameter int EXP_OUT    = (IMG_W - 2) * (IMG_H - 2),
  parameter int DRAIN_MAX  = IMG_W * 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     pause,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  output logic [15:0]              out_count,
  conv2d_frame_sequencer_if.master bus
);

  localparam int                NPIX       = npix(IMG_W, IMG_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NPIX - 1);
  localparam logic [15:0]       EXP_CNT    = 16'(EXP_OUT);
  localparam logic [15:0]       DRAIN_LAST = 16'(DRAIN_MAX - 1);

  seq_state_t        state;
  seq_state_t        state_next;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] last_addr;
  logic [15:0]       drain_cnt;
  logic              pixel_valid_q;
  logic              rd_fire;
  logic              accept;
  logic              drain_expire;
  logic              counting;
  logic              count_hit;

  // Core outputs are only meaningful while a frame is in flight (FEED..DONE).
  assign counting  = (state != IDLE);
  assign count_hit = counting && bus.core_out_vld;

  // The address bus shows the live address on a read and otherwise the last one issued.
  assign bus.mem_rd_en   = rd_fire;
  assign bus.mem_addr    = rd_fire ? addr : last_addr;
  assign bus.pixel_valid = pixel_valid_q;
  // The RAM output register supplies the data in the pixel_valid cycle; zero the stream otherwise.
  assign bus.pixel_in    = pixel_valid_q ? bus.mem_rd_data : {PIXEL_BITS{1'b0}};

  // Next-state and per-state strobes.
  always_comb begin
    state_next   = state;
    rd_fire      = 1'b0;
    accept       = 1'b0;
    drain_expire = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = FEED;
        end
      end
      FEED: begin
        busy = 1'b1;
        if (!pause) begin
          rd_fire = 1'b1;
          if (addr == LAST_ADDR) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        // Reaching (or overshooting) the expected count ends the frame normally.
        if (out_count >= EXP_CNT) begin
          state_next = DONE;
        end else if (drain_cnt == DRAIN_LAST) begin
          drain_expire = 1'b1;
          state_next   = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Read address counter and the held copy shown while no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      last_addr <= '0;
    end else if (accept) begin
      addr <= '0;
    end else if (rd_fire) begin
      addr      <= addr + 1'b1;
      last_addr <= addr;
    end
  end

  // Drain cycle counter, held at zero outside DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= '0;
    end else if (state != DRAIN) begin
      drain_cnt <= '0;
    end else begin
      drain_cnt <= drain_cnt + 16'd1;
    end
  end

  // Saturating output counter and sticky error flag, both cleared by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count   <= '0;
      timeout_err <= 1'b0;
    end else if (accept) begin
      out_count   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (count_hit && (out_count != 16'hFFFF)) begin
        out_count <= out_count + 16'd1;
      end
      if ((count_hit && (out_count >= EXP_CNT)) || drain_expire) begin
        timeout_err <= 1'b1;
      end
    end
  end

  // Pixel qualifier trails the read strobe by one cycle to match RAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_valid_q <= 1'b0;
    end else begin
      pixel_valid_q <= rd_fire;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv2d_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_conv2d_frame_sequencer                                   |
// | Description : Self-checking bench for conv2d_frame_sequencer with a      |
// |               behavioural frame model and randomized pause/pulses.       |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module tb_conv2d_frame_sequencer;

  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int EXP_OUT = 4;
  localparam int DRAIN_MAX = 12;
  localparam int ADDR_W = 4;
  localparam int PIXEL_BITS = 8;

  localparam int P_IDLE = 0;
  localparam int P_FEED = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic busy, done, timeout_err;
  logic [15:0] out_count;

  conv2d_frame_sequencer_if #(.ADDR_W(ADDR_W), .PIXEL_BITS(PIXEL_BITS)) bus ();

  conv2d_frame_sequencer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .PIXEL_BITS(PIXEL_BITS), .ADDR_W(ADDR_W),
    .EXP_OUT(EXP_OUT), .DRAIN_MAX(DRAIN_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
    .busy(busy), .done(done), .timeout_err(timeout_err),
    .out_count(out_count), .bus(bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame RAM: holds address as data, registered read.
  logic [PIXEL_BITS-1:0] ram [NPIX];
  initial for (int i = 0; i < NPIX; i++) ram[i] = PIXEL_BITS'(i);
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_addr];

  initial bus.core_out_vld = 1'b0;

  // Behavioural frame model: phase, next address to read, outputs seen, error flag.
  int m_phase, m_next, m_last, m_drain, m_outs, m_prev_addr;
  bit m_err, m_prev_rd, m_rd, m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_IDLE; m_next = 0; m_last = 0; m_drain = 0; m_outs = 0;
      m_err = 0; m_prev_rd = 0; m_prev_addr = 0;
    end else begin
      m_rd = (m_phase == P_FEED) && !pause;
      m_cnt = (m_phase != P_IDLE) && bus.core_out_vld;
      m_prev_rd = m_rd;
      m_prev_addr = m_next;
      case (m_phase)
        P_IDLE: if (start) begin
          m_phase = P_FEED; m_next = 0; m_outs = 0; m_err = 0;
        end
        P_FEED: if (m_rd) begin
          m_last = m_next;
          if (m_next == NPIX - 1) begin m_phase = P_DRAIN; m_drain = 0; end
          m_next++;
        end
        P_DRAIN: begin
          if (m_outs >= EXP_OUT) m_phase = P_DONE;
          else if (m_drain == DRAIN_MAX - 1) begin m_err = 1; m_phase = P_DONE; end
          else m_drain++;
        end
        default: m_phase = P_IDLE;
      endcase
      if (m_cnt) begin
        if (m_outs >= EXP_OUT) m_err = 1;
        if (m_outs < 65535) m_outs++;
      end
    end
  end

  // Compare process: every cycle, on the falling edge.
  logic [PIXEL_BITS-1:0] pix_q [$];
  bit e_rd;
  logic [ADDR_W-1:0] e_addr;
  logic [PIXEL_BITS-1:0] e_pix;
  always @(negedge clk) begin
    e_rd = (m_phase == P_FEED) && !pause;
    e_addr = ADDR_W'(e_rd ? m_next : m_last);
    e_pix = m_prev_rd ? ram[m_prev_addr] : '0;
    chk("mem_rd_en", 32'(bus.mem_rd_en), 32'(e_rd));
    chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
    chk("busy", 32'(busy), 32'((m_phase == P_FEED) || (m_phase == P_DRAIN)));
    chk("done", 32'(done), 32'(m_phase == P_DONE));
    chk("pixel_valid", 32'(bus.pixel_valid), 32'(m_prev_rd));
    chk("pixel_in", 32'(bus.pixel_in), 32'(e_pix));
    chk("timeout_err", 32'(timeout_err), 32'(m_err));
    chk("out_count", 32'(out_count), 32'(m_outs));
    if (bus.pixel_valid) pix_q.push_back(bus.pixel_in);
  end

  // Runs one frame starting from IDLE at posedge+1; returns at posedge+1 of the cycle after done.
  // pmode: 0 none, 1 random pause, 2 three-cycle pause after address 5.
  task automatic run_frame(input int n_out, input int pmode, input bit restart_mid,
                           input int abort_addr, input bit exp_err, input int exp_drain);
    int sched [6];
    int cyc, k, pause_left, drain_len, dones;
    bit seen_done, last_seen, want_resume;
    for (int i = 0; i < 6; i++) sched[i] = 2 + 2 * i + int'($urandom_range(0, 1));
    pix_q.delete();
    cyc = 0; k = 0; pause_left = 0; drain_len = 0; dones = 0;
    seen_done = 0; last_seen = 0; want_resume = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!seen_done && cyc < 200) begin
      if (pmode == 1) pause = ($urandom_range(0, 3) == 0);
      else if (pmode == 2) begin pause = (pause_left > 0); if (pause_left > 0) pause_left--; end
      else pause = 1'b0;
      bus.core_out_vld = (k < n_out) && (cyc == sched[k]);
      if (bus.core_out_vld) k++;
      start = restart_mid && (cyc == 5);
      @(negedge clk);
      if (cyc == 0) chk("err_cleared_on_start", 32'(timeout_err), 32'(0));
      if (pmode == 2 && pause) chk("read_during_pause", 32'(bus.mem_rd_en), 32'(0));
      if (want_resume && !pause && bus.mem_rd_en) begin
        chk("resume_addr", 32'(bus.mem_addr), 32'(6));
        want_resume = 0;
      end
      if (pmode == 2 && bus.mem_rd_en && bus.mem_addr == 4'd5) begin pause_left = 3; want_resume = 1; end
      if (abort_addr >= 0 && bus.mem_rd_en && int'(bus.mem_addr) == abort_addr) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0); chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(timeout_err), 0); chk("rst_count", 32'(out_count), 0);
        chk("rst_rd_en", 32'(bus.mem_rd_en), 0); chk("rst_addr", 32'(bus.mem_addr), 0);
        chk("rst_pvalid", 32'(bus.pixel_valid), 0); chk("rst_pix", 32'(bus.pixel_in), 0);
        chk("abort_no_done", 32'(dones), 0);
        start = 0; pause = 0; bus.core_out_vld = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      if (last_seen && busy) drain_len++;
      if (bus.mem_rd_en && int'(bus.mem_addr) == NPIX - 1) last_seen = 1;
      if (done) begin seen_done = 1; dones++; end
      @(posedge clk); #1;
      cyc++;
    end
    start = 0; pause = 0; bus.core_out_vld = 0;
    if (abort_addr >= 0) chk("abort_addr_reached", 0, 1);
    if (!seen_done) begin
      errors++; checks++;
      $display("FAIL done_timeout: no done within 200 cycles");
      return;
    end
    chk("frame_out_count", 32'(out_count), 32'(n_out));
    chk("frame_timeout_err", 32'(timeout_err), 32'(exp_err));
    chk("frame_pixel_count", 32'(pix_q.size()), 32'(NPIX));
    chk("frame_drain_len", 32'(drain_len), 32'(exp_drain));
    for (int i = 0; i < NPIX && i < pix_q.size(); i++) chk("frame_pixel_seq", 32'(pix_q[i]), 32'(i));
  endtask

  int n;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_count", 32'(out_count), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(4, 0, 0, -1, 0, 1);            // plain frame
    run_frame(4, 2, 0, -1, 0, 1);            // pause after address 5
    run_frame(3, 0, 0, -1, 1, DRAIN_MAX);    // too few outputs -> drain timeout
    run_frame(4, 0, 1, -1, 0, 1);            // back-to-back start clears error, mid-frame start ignored
    run_frame(4, 0, 0, 9, 0, 0);             // reset at address 9
    run_frame(4, 0, 0, -1, 0, 1);            // restart after reset reads from 0
    run_frame(5, 0, 0, -1, 1, 1);            // excess outputs
    for (int f = 0; f < 8; f++) begin
      n = int'($urandom_range(3, 5));
      run_frame(n, 1, 1'($urandom_range(0, 1)), -1, n != EXP_OUT, (n == 3) ? DRAIN_MAX : 1);
    end
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
